// File: rtl/icache_mem_req_queue.sv
// Request queue between the icache memory adapter and the fetch memory model.
// Buffers requests in a small FIFO, caps in-flight requests, and passes acks straight through.
module icache_mem_req_queue #(
  parameter int ADDR_W          = 32,
  parameter int TAG_W           = 16,
  parameter int DATA_W          = 64,
  parameter int REQ_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               up_req_vld,
  output logic                               up_req_rdy,
  input  logic [ADDR_W-1:0]                  up_req_addr,
  input  logic [TAG_W-1:0]                   up_req_tag,
  output logic                               mem_req_vld,
  input  logic                               mem_req_rdy,
  output logic [ADDR_W-1:0]                  mem_req_addr,
  output logic [TAG_W-1:0]                   mem_req_tag,
  input  logic                               mem_ack_vld,
  output logic                               mem_ack_rdy,
  input  logic [DATA_W-1:0]                  mem_ack_data,
  input  logic [TAG_W-1:0]                   mem_ack_tag,
  output logic                               up_ack_vld,
  input  logic                               up_ack_rdy,
  output logic [DATA_W-1:0]                  up_ack_data,
  output logic [TAG_W-1:0]                   up_ack_tag,
  output logic [$clog2(REQ_DEPTH):0]         req_cnt,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_cnt,
  output logic                               err_ack_underflow,
  output logic                               idle
);

  localparam int PTR_W = $clog2(REQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [ADDR_W-1:0] addr_mem [REQ_DEPTH];
  logic [TAG_W-1:0]  tag_mem  [REQ_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              push;
  logic              pop;
  logic              ack;

  // Readiness looks only at occupancy, so a full FIFO refuses even on a pop cycle.
  assign up_req_rdy  = (req_cnt < CNT_W'(REQ_DEPTH)) & ~rst;
  assign mem_req_vld = (req_cnt != '0) & (outstanding_cnt < OUT_W'(MAX_OUTSTANDING)) & ~rst;
  assign mem_req_addr = addr_mem[rptr];
  assign mem_req_tag  = tag_mem[rptr];

  assign mem_ack_rdy = up_ack_rdy & ~rst;
  assign up_ack_vld  = mem_ack_vld & ~rst;
  assign up_ack_data = mem_ack_data;
  assign up_ack_tag  = mem_ack_tag;

  assign push = up_req_vld & up_req_rdy;
  assign pop  = mem_req_vld & mem_req_rdy;
  assign ack  = mem_ack_vld & mem_ack_rdy;

  assign idle = (req_cnt == '0) && (outstanding_cnt == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr] <= up_req_addr;
      tag_mem[wptr]  <= up_req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr              <= '0;
      rptr              <= '0;
      req_cnt           <= '0;
      outstanding_cnt   <= '0;
      err_ack_underflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;

      case ({push, pop})
        2'b10:   req_cnt <= req_cnt + 1'b1;
        2'b01:   req_cnt <= req_cnt - 1'b1;
        default: req_cnt <= req_cnt;
      endcase

      // An ack with nothing in flight saturates at zero and flags the protocol error.
      if (pop && !ack) begin
        outstanding_cnt <= outstanding_cnt + 1'b1;
      end else if (ack && !pop) begin
        if (outstanding_cnt == '0) err_ack_underflow <= 1'b1;
        else                       outstanding_cnt   <= outstanding_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_mem_req_queue.sv
// Directed bench for icache_mem_req_queue; issued requests are checked by a scoreboard monitor.
module tb_icache_mem_req_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_req_vld;
  logic        up_req_rdy;
  logic [31:0] up_req_addr;
  logic [15:0] up_req_tag;
  logic        mem_req_vld;
  logic        mem_req_rdy;
  logic [31:0] mem_req_addr;
  logic [15:0] mem_req_tag;
  logic        mem_ack_vld;
  logic        mem_ack_rdy;
  logic [31:0] mem_ack_data;
  logic [15:0] mem_ack_tag;
  logic        up_ack_vld;
  logic        up_ack_rdy;
  logic [31:0] up_ack_data;
  logic [15:0] up_ack_tag;
  logic [2:0]  req_cnt;
  logic [3:0]  outstanding_cnt;
  logic        err_ack_underflow;
  logic        idle;

  icache_mem_req_queue #(
    .ADDR_W(32), .TAG_W(16), .DATA_W(32), .REQ_DEPTH(4), .MAX_OUTSTANDING(8)
  ) dut (
    .clk(clk), .rst(rst),
    .up_req_vld(up_req_vld), .up_req_rdy(up_req_rdy),
    .up_req_addr(up_req_addr), .up_req_tag(up_req_tag),
    .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_ack_vld(mem_ack_vld), .mem_ack_rdy(mem_ack_rdy),
    .mem_ack_data(mem_ack_data), .mem_ack_tag(mem_ack_tag),
    .up_ack_vld(up_ack_vld), .up_ack_rdy(up_ack_rdy),
    .up_ack_data(up_ack_data), .up_ack_tag(up_ack_tag),
    .req_cnt(req_cnt), .outstanding_cnt(outstanding_cnt),
    .err_ack_underflow(err_ack_underflow), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_issue = 0;
  int issue_base;
  logic [47:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  // Drive a request; when it is expected to be accepted, record what must come out the other side.
  task automatic req(input logic [31:0] a, input bit acc);
    logic [15:0] t;
    t = a[15:0] ^ 16'h5a5a;
    up_req_vld  = 1'b1;
    up_req_addr = a;
    up_req_tag  = t;
    if (acc) exp_q.push_back({a, t});
  endtask

  // Scoreboard monitor: every issued request must match the next expected entry in order.
  always @(negedge clk) begin
    if (!rst && mem_req_vld && mem_req_rdy) begin
      n_issue++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected_issue: got addr 0x%0h with no request pending", mem_req_addr);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        chk("sb_issue_addr", mem_req_addr, e[47:16]);
        chk("sb_issue_tag", 32'(mem_req_tag), 32'(e[15:0]));
      end
    end
    if (!rst && mem_ack_vld) begin
      chk("ack_pass_vld", 32'(up_ack_vld), 1);
      chk("ack_pass_data", up_ack_data, mem_ack_data);
      chk("ack_pass_tag", 32'(up_ack_tag), 32'(mem_ack_tag));
    end
  end

  initial begin
    rst = 1'b1;
    up_req_vld = 1'b1; up_req_addr = '0; up_req_tag = '0;
    mem_req_rdy = 1'b1; mem_ack_vld = 1'b1; up_ack_rdy = 1'b1;
    mem_ack_data = 32'hd000_0000; mem_ack_tag = 16'h0;

    // Reset: handshake outputs gated off even with active inputs.
    tick(); tick(); nedge();
    chk("rst_up_req_rdy", 32'(up_req_rdy), 0);
    chk("rst_mem_req_vld", 32'(mem_req_vld), 0);
    chk("rst_up_ack_vld", 32'(up_ack_vld), 0);
    chk("rst_mem_ack_rdy", 32'(mem_ack_rdy), 0);
    tick();
    rst = 1'b0; up_req_vld = 1'b0; mem_ack_vld = 1'b0; mem_req_rdy = 1'b0;
    nedge();
    chk("post_rst_idle", 32'(idle), 1);
    chk("post_rst_req_cnt", 32'(req_cnt), 0);
    chk("post_rst_outstanding", 32'(outstanding_cnt), 0);
    chk("post_rst_err", 32'(err_ack_underflow), 0);

    // In-order issue with immediate acks.
    tick(); mem_req_rdy = 1'b1; req(32'h100, 1'b1); nedge();
    chk("wrap_rdy", 32'(up_req_rdy), 1);
    chk("wrap_no_bypass", 32'(mem_req_vld), 0);
    tick(); req(32'h140, 1'b1); nedge();
    chk("wrap_issue_vld", 32'(mem_req_vld), 1);
    tick(); req(32'h180, 1'b1);
    mem_ack_vld = 1'b1; mem_ack_tag = 16'h5b5a; mem_ack_data = 32'hd000_0100; nedge();
    chk("wrap_outst_1a", 32'(outstanding_cnt), 1);
    tick(); up_req_vld = 1'b0; mem_ack_tag = 16'h5b1a; mem_ack_data = 32'hd000_0140; nedge();
    chk("wrap_outst_1b", 32'(outstanding_cnt), 1);
    tick(); mem_ack_tag = 16'h5bda; mem_ack_data = 32'hd000_0180; nedge();
    chk("wrap_outst_1c", 32'(outstanding_cnt), 1);
    chk("wrap_drained_vld", 32'(mem_req_vld), 0);
    tick(); mem_ack_vld = 1'b0; nedge();
    chk("wrap_outst_0", 32'(outstanding_cnt), 0);
    chk("wrap_idle", 32'(idle), 1);

    // FIFO full with memory stalled.
    mem_req_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); req(32'h300 + 32'(i) * 32'h40, 1'b1); nedge();
      chk("full_fill_rdy", 32'(up_req_rdy), 1);
    end
    tick(); req(32'h400, 1'b0); nedge();
    chk("full_req_cnt", 32'(req_cnt), 4);
    chk("full_rdy_low", 32'(up_req_rdy), 0);
    tick(); mem_req_rdy = 1'b1; nedge();
    chk("full_pop_cycle_rdy", 32'(up_req_rdy), 0);
    chk("full_pop_cycle_vld", 32'(mem_req_vld), 1);
    tick(); mem_req_rdy = 1'b0; req(32'h400, 1'b1); nedge();
    chk("full_freed_req_cnt", 32'(req_cnt), 3);
    chk("full_freed_rdy", 32'(up_req_rdy), 1);
    tick(); up_req_vld = 1'b0; nedge();
    chk("full_refill_cnt", 32'(req_cnt), 4);
    chk("full_outst", 32'(outstanding_cnt), 1);
    for (int i = 0; i < 4; i++) begin
      tick(); mem_req_rdy = 1'b1; mem_ack_vld = 1'b1; nedge();
      chk("full_drain_outst", 32'(outstanding_cnt), 1);
    end
    tick(); nedge();
    chk("full_drain_vld", 32'(mem_req_vld), 0);
    tick(); mem_ack_vld = 1'b0; nedge();
    chk("full_idle", 32'(idle), 1);

    // Outstanding cap at 8 with no acks.
    issue_base = n_issue;
    for (int i = 0; i < 10; i++) begin
      tick(); mem_req_rdy = 1'b1; req(32'h1000 + 32'(i) * 32'h40, 1'b1); nedge();
      chk("cap_push_rdy", 32'(up_req_rdy), 1);
    end
    tick(); up_req_vld = 1'b0; nedge();
    chk("cap_outst_8", 32'(outstanding_cnt), 8);
    chk("cap_vld_low", 32'(mem_req_vld), 0);
    chk("cap_req_cnt", 32'(req_cnt), 2);
    chk("cap_issue_count", 32'(n_issue - issue_base), 8);
    tick(); mem_ack_vld = 1'b1; nedge();
    chk("cap_ack_cycle_vld", 32'(mem_req_vld), 0);
    tick(); mem_ack_vld = 1'b0; nedge();
    chk("cap_after_ack_outst", 32'(outstanding_cnt), 7);
    chk("cap_9th_vld", 32'(mem_req_vld), 1);
    tick(); nedge();
    chk("cap_9th_outst", 32'(outstanding_cnt), 8);
    chk("cap_9th_req_cnt", 32'(req_cnt), 1);

    // Simultaneous issue and ack, then ack blocked by the adapter.
    for (int i = 0; i < 5; i++) begin
      tick(); mem_req_rdy = 1'b0; mem_ack_vld = 1'b1; nedge();
    end
    tick(); mem_req_rdy = 1'b1; nedge();
    chk("sim_pre_outst", 32'(outstanding_cnt), 3);
    chk("sim_pre_vld", 32'(mem_req_vld), 1);
    tick(); mem_req_rdy = 1'b0; up_ack_rdy = 1'b0; nedge();
    chk("sim_outst_3", 32'(outstanding_cnt), 3);
    chk("sim_req_cnt_0", 32'(req_cnt), 0);
    chk("blk_mem_ack_rdy", 32'(mem_ack_rdy), 0);
    tick(); up_ack_rdy = 1'b1; mem_ack_vld = 1'b0; nedge();
    chk("blk_outst_3", 32'(outstanding_cnt), 3);
    for (int i = 0; i < 3; i++) begin
      tick(); mem_ack_vld = 1'b1; nedge();
    end
    tick(); mem_ack_vld = 1'b0; nedge();
    chk("sim_drain_outst", 32'(outstanding_cnt), 0);
    chk("sim_drain_idle", 32'(idle), 1);
    chk("sim_err_clear", 32'(err_ack_underflow), 0);

    // Ack with nothing in flight.
    tick(); mem_ack_vld = 1'b1; nedge();
    tick(); mem_ack_vld = 1'b0; nedge();
    chk("unf_err_set", 32'(err_ack_underflow), 1);
    chk("unf_outst_0", 32'(outstanding_cnt), 0);
    tick(); tick(); tick(); nedge();
    chk("unf_err_sticky", 32'(err_ack_underflow), 1);

    // Mid-operation reset with two queued and five in flight.
    for (int k = 0; k < 7; k++) begin
      tick(); mem_req_rdy = (k <= 5); req(32'h2000 + 32'(k) * 32'h40, 1'b1); nedge();
    end
    tick(); up_req_vld = 1'b0; mem_req_rdy = 1'b0; nedge();
    chk("mid_req_cnt_2", 32'(req_cnt), 2);
    chk("mid_outst_5", 32'(outstanding_cnt), 5);
    tick(); rst = 1'b1; up_req_vld = 1'b1; mem_req_rdy = 1'b1; mem_ack_vld = 1'b1; nedge();
    chk("mid_rst_up_req_rdy", 32'(up_req_rdy), 0);
    chk("mid_rst_mem_req_vld", 32'(mem_req_vld), 0);
    chk("mid_rst_up_ack_vld", 32'(up_ack_vld), 0);
    chk("mid_rst_mem_ack_rdy", 32'(mem_ack_rdy), 0);
    exp_q.delete();
    tick(); rst = 1'b0; up_req_vld = 1'b0; mem_req_rdy = 1'b0; mem_ack_vld = 1'b0; nedge();
    chk("mid_post_req_cnt", 32'(req_cnt), 0);
    chk("mid_post_outst", 32'(outstanding_cnt), 0);
    chk("mid_post_idle", 32'(idle), 1);
    chk("mid_post_err", 32'(err_ack_underflow), 0);

    // Fresh request after reset must come from a cleanly reset head.
    tick(); req(32'h3000, 1'b1); nedge();
    chk("fresh_no_bypass", 32'(mem_req_vld), 0);
    tick(); up_req_vld = 1'b0; mem_req_rdy = 1'b1; nedge();
    chk("fresh_vld", 32'(mem_req_vld), 1);
    tick(); mem_req_rdy = 1'b0; mem_ack_vld = 1'b1; nedge();
    tick(); mem_ack_vld = 1'b0; nedge();
    chk("fresh_idle", 32'(idle), 1);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
